// File: rtl/pixel_control_pkg.sv
// Shared constants and helpers for the pixel column readout sequencer.
package pixel_control_pkg;

   localparam int PH_COMP1 = 32;   // first comparator-reset cycle
   localparam int PH_COMP2 = 40;   // staggered hand-over to RST_COMP2
   localparam int PH_VTH   = 48;   // comparator resets end, CDS_VTH begins
   localparam int MAX_MEM  = 8;
   localparam int COL_W    = 3;

   typedef enum logic {SEQ_IDLE, SEQ_RUN} seq_state_t;

   // Index of the last readable memory: READ_MEM clamped to 1..MAX_MEM, minus one.
   function automatic logic [COL_W-1:0] last_mem_idx(input logic [3:0] read_mem);
      if (read_mem == 4'd0)
         return '0;
      else if (read_mem >= 4'(MAX_MEM))
         return COL_W'(MAX_MEM - 1);
      else
         return COL_W'(read_mem - 4'd1);
   endfunction

endpackage

// File: rtl/pixel_control_if.sv
// Control/status bundle between the slow-control block and the column sequencer.
interface pixel_control_if;
   import pixel_control_pkg::*;

   logic             PIX_RESET;
   logic             PIX_STORE;
   logic             COMP_EN_SEL;
   logic             MEM_SET_EN;
   logic             MEM_SET_CLR;
   logic             REGOUT_EN;
   logic [3:0]       READ_MEM;
   logic             TRG_MODE;
   logic             TRG_DET;
   logic             EVT_NUM_END;

   logic             CF_RST;
   logic             CDS_RST;
   logic             RST_COMP1;
   logic             RST_COMP2;
   logic             CDS_VTH;
   logic             PIX_RESET_BUSY;
   logic             PIX_END;
   logic             STORE;
   logic             READ_PIX;
   logic             MEM_SET_DONE;
   logic             LAST_MEM;
   logic [COL_W-1:0] COLOUT_SEL;
   logic             REGOUT_SEL;

   modport master (
      output PIX_RESET, PIX_STORE, COMP_EN_SEL, MEM_SET_EN, MEM_SET_CLR, REGOUT_EN,
             READ_MEM, TRG_MODE, TRG_DET, EVT_NUM_END,
      input  CF_RST, CDS_RST, RST_COMP1, RST_COMP2, CDS_VTH, PIX_RESET_BUSY, PIX_END,
             STORE, READ_PIX, MEM_SET_DONE, LAST_MEM, COLOUT_SEL, REGOUT_SEL
   );

   modport slave (
      input  PIX_RESET, PIX_STORE, COMP_EN_SEL, MEM_SET_EN, MEM_SET_CLR, REGOUT_EN,
             READ_MEM, TRG_MODE, TRG_DET, EVT_NUM_END,
      output CF_RST, CDS_RST, RST_COMP1, RST_COMP2, CDS_VTH, PIX_RESET_BUSY, PIX_END,
             STORE, READ_PIX, MEM_SET_DONE, LAST_MEM, COLOUT_SEL, REGOUT_SEL
   );

endinterface

// File: rtl/pixel_mem_sel.sv
// Memory-column pointer: steps on MEM_SET_EN rising edges, saturates at the last memory.
module pixel_mem_sel
   import pixel_control_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_set_en,
   input  logic             mem_set_clr,
   input  logic [3:0]       read_mem,
   output logic             read_pix,
   output logic             mem_set_done,
   output logic             last_mem,
   output logic [COL_W-1:0] colout_sel
);

   logic             en_d;
   logic             step;
   logic             read_pix_n;
   logic             done_n;
   logic [COL_W-1:0] col_n;
   logic [COL_W-1:0] last_idx;

   assign step     = mem_set_en & ~en_d;
   assign last_idx = last_mem_idx(read_mem);

   always_comb begin
      read_pix_n = read_pix;
      col_n      = colout_sel;
      done_n     = 1'b0;
      if (mem_set_clr) begin
         read_pix_n = 1'b0;
         col_n      = '0;
      end else if (step) begin
         done_n = 1'b1;
         if (!read_pix) begin
            read_pix_n = 1'b1;
            col_n      = '0;
         end else if (colout_sel < last_idx) begin
            col_n = colout_sel + 1'b1;
         end
      end
   end

   // en_d tracks the input during reset so a level held through reset is not an edge.
   always_ff @(posedge clk) begin
      en_d <= mem_set_en;
      if (rst) begin
         read_pix     <= 1'b0;
         colout_sel   <= '0;
         mem_set_done <= 1'b0;
         last_mem     <= 1'b0;
      end else begin
         read_pix     <= read_pix_n;
         colout_sel   <= col_n;
         mem_set_done <= done_n;
         last_mem     <= read_pix_n && (col_n == last_idx);
      end
   end

endmodule

// File: rtl/pixel_control.sv
// Column readout sequencer: counter-driven reset/CDS strobes, STORE window, memory pointer.
module pixel_control
   import pixel_control_pkg::*;
#(
   parameter int SEQ_LEN = 64,
   parameter int CF_END  = 16,
   parameter int CDS_END = 32
) (
   input logic             CLK,
   input logic             RST,
   pixel_control_if.slave  pif
);

   localparam int               CNT_W    = $clog2(SEQ_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEQ_LEN - 1);

   seq_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             mode, mode_n;
   logic             pix_reset_d, pix_rise;
   logic             run_n;
   int               c_int;
   logic             cf_n, cds_n, comp1_n, comp2_n, vth_n, end_n, store_n;
   logic             cf_rst, cds_rst, rst_comp1, rst_comp2, cds_vth, pix_end, store, regout_sel;

   assign pix_rise = pif.PIX_RESET & ~pix_reset_d;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      mode_n  = mode;
      unique case (state)
         SEQ_IDLE: if (pix_rise) begin
            state_n = SEQ_RUN;
            cnt_n   = '0;
            mode_n  = pif.COMP_EN_SEL;
         end
         SEQ_RUN: if (cnt == CNT_LAST) begin
            state_n = SEQ_IDLE;
            cnt_n   = '0;
         end else begin
            cnt_n = cnt + 1'b1;
         end
         default: state_n = SEQ_IDLE;
      endcase

      // Strobes are decoded from the next count so they register in step with it.
      run_n   = (state_n == SEQ_RUN);
      c_int   = int'(cnt_n);
      cf_n    = run_n && (c_int < CF_END);
      cds_n   = run_n && (c_int < CDS_END);
      comp1_n = run_n && (c_int >= PH_COMP1) && (c_int < (mode_n ? PH_VTH : PH_COMP2));
      comp2_n = run_n && (c_int >= (mode_n ? PH_COMP1 : PH_COMP2)) && (c_int < PH_VTH);
      vth_n   = run_n && (c_int >= PH_VTH);
      end_n   = run_n && (cnt_n == CNT_LAST);

      store_n = store;
      if (pix_end && pif.PIX_STORE)
         store_n = 1'b1;
      if (!pif.PIX_STORE || (pif.TRG_MODE && pif.TRG_DET) || pif.EVT_NUM_END)
         store_n = 1'b0;
      if (run_n)
         store_n = 1'b0;
   end

   always_ff @(posedge CLK) begin
      pix_reset_d <= pif.PIX_RESET;
      if (RST) begin
         state      <= SEQ_IDLE;
         cnt        <= '0;
         mode       <= 1'b0;
         cf_rst     <= 1'b0;
         cds_rst    <= 1'b0;
         rst_comp1  <= 1'b0;
         rst_comp2  <= 1'b0;
         cds_vth    <= 1'b0;
         pix_end    <= 1'b0;
         store      <= 1'b0;
         regout_sel <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         mode       <= mode_n;
         cf_rst     <= cf_n;
         cds_rst    <= cds_n;
         rst_comp1  <= comp1_n;
         rst_comp2  <= comp2_n;
         cds_vth    <= vth_n;
         pix_end    <= end_n;
         store      <= store_n;
         regout_sel <= pif.REGOUT_EN;
      end
   end

   assign pif.CF_RST         = cf_rst;
   assign pif.CDS_RST        = cds_rst;
   assign pif.RST_COMP1      = rst_comp1;
   assign pif.RST_COMP2      = rst_comp2;
   assign pif.CDS_VTH        = cds_vth;
   assign pif.PIX_RESET_BUSY = (state == SEQ_RUN);
   assign pif.PIX_END        = pix_end;
   assign pif.STORE          = store;
   assign pif.REGOUT_SEL     = regout_sel;

   pixel_mem_sel u_mem_sel (
      .clk          (CLK),
      .rst          (RST),
      .mem_set_en   (pif.MEM_SET_EN),
      .mem_set_clr  (pif.MEM_SET_CLR),
      .read_mem     (pif.READ_MEM),
      .read_pix     (pif.READ_PIX),
      .mem_set_done (pif.MEM_SET_DONE),
      .last_mem     (pif.LAST_MEM),
      .colout_sel   (pif.COLOUT_SEL)
   );

endmodule

// File: tb/tb_pixel_control.sv
// Directed bench for pixel_control: strobe timeline, STORE window, memory pointer, reset.
module tb_pixel_control;
   import pixel_control_pkg::*;

   typedef struct {
      logic [3:0] read_mem;
      int         steps;
      logic [2:0] col;
      logic       last;
   } mem_vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   pixel_control_if pif();

   pixel_control #(.SEQ_LEN(64), .CF_END(16), .CDS_END(32)) dut (
      .CLK (clk),
      .RST (rst),
      .pif (pif.slave)
   );

   always #5 clk = ~clk;

   logic [6:0]  seq_out;
   logic [13:0] all_out;
   assign seq_out = {pif.CF_RST, pif.CDS_RST, pif.RST_COMP1, pif.RST_COMP2, pif.CDS_VTH,
                     pif.PIX_RESET_BUSY, pif.PIX_END};
   assign all_out = {seq_out, pif.STORE, pif.READ_PIX, pif.MEM_SET_DONE, pif.LAST_MEM,
                     pif.COLOUT_SEL, pif.REGOUT_SEL};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Expected {CF,CDS,COMP1,COMP2,VTH,BUSY,END} at count c for a 64-cycle sequence.
   function automatic logic [6:0] exp_seq(input int c, input bit sim);
      logic cf, cds, c1, c2, vth, en;
      cf  = (c < 16);
      cds = (c < 32);
      c1  = sim ? (c >= 32 && c < 48) : (c >= 32 && c < 40);
      c2  = sim ? (c >= 32 && c < 48) : (c >= 40 && c < 48);
      vth = (c >= 48);
      en  = (c == 63);
      return {cf, cds, c1, c2, vth, 1'b1, en};
   endfunction

   task automatic pulse_reset();
      pif.PIX_RESET = 1'b1;
      tick();
      pif.PIX_RESET = 1'b0;
   endtask

   task automatic run_seq();
      pulse_reset();
      for (int i = 0; i < 80 && pif.PIX_RESET_BUSY; i++) tick();
      chk("seq_done_bound", pif.PIX_RESET_BUSY, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      mem_vec_t tbl[8];
      int ends, end_at, dones, seen;

      tbl[0] = '{4'd0,  1, 3'd0, 1'b1};
      tbl[1] = '{4'd1,  3, 3'd0, 1'b1};
      tbl[2] = '{4'd2,  1, 3'd0, 1'b0};
      tbl[3] = '{4'd2,  2, 3'd1, 1'b1};
      tbl[4] = '{4'd4,  3, 3'd2, 1'b0};
      tbl[5] = '{4'd8,  8, 3'd7, 1'b1};
      tbl[6] = '{4'd9,  5, 3'd4, 1'b0};
      tbl[7] = '{4'd15, 9, 3'd7, 1'b1};

      rst = 1'b1;
      pif.PIX_RESET = 0; pif.PIX_STORE = 0; pif.COMP_EN_SEL = 0; pif.MEM_SET_EN = 0;
      pif.MEM_SET_CLR = 0; pif.REGOUT_EN = 0; pif.READ_MEM = 4'd4; pif.TRG_MODE = 0;
      pif.TRG_DET = 0; pif.EVT_NUM_END = 0;
      repeat (3) tick();
      chk("reset_outs", all_out, 0);
      rst = 1'b0;
      tick();
      chk("post_reset_outs", all_out, 0);

      // Basic staggered sequence with STORE window
      pif.PIX_STORE = 1'b1;
      pulse_reset();
      for (int c = 0; c < 64; c++) begin
         chk($sformatf("basic_c%0d", c), seq_out, exp_seq(c, 1'b0));
         chk($sformatf("basic_store_c%0d", c), pif.STORE, 0);
         tick();
      end
      chk("basic_after", seq_out, 0);
      chk("store_set", pif.STORE, 1);
      pif.PIX_STORE = 1'b0;
      tick();
      chk("store_drop", pif.STORE, 0);

      // Simultaneous mode, COMP_EN_SEL toggled mid-sequence
      pif.COMP_EN_SEL = 1'b1;
      pulse_reset();
      for (int c = 0; c < 64; c++) begin
         chk($sformatf("sim_c%0d", c), seq_out, exp_seq(c, 1'b1));
         if (c == 20) pif.COMP_EN_SEL = 1'b0;
         tick();
      end
      chk("sim_after", seq_out, 0);

      // Re-trigger while busy
      pulse_reset();
      ends = 0; end_at = -1; seen = 0;
      for (int i = 0; i < 80; i++) begin
         if (pif.PIX_END) begin ends++; end_at = i; end
         if (i >= 64 && pif.PIX_RESET_BUSY) seen++;
         if (i == 10) pif.PIX_RESET = 1'b1;
         if (i == 11) pif.PIX_RESET = 1'b0;
         tick();
      end
      chk("retrig_end_count", ends, 1);
      chk("retrig_end_at", end_at, 63);
      chk("retrig_no_restart", seen, 0);

      // STORE abort paths
      pif.PIX_STORE = 1'b1;
      run_seq();
      chk("abort_store_set", pif.STORE, 1);
      pif.TRG_DET = 1'b1;
      tick();
      chk("trgdet_no_mode", pif.STORE, 1);
      pif.TRG_MODE = 1'b1;
      tick();
      chk("trg_abort", pif.STORE, 0);
      pif.TRG_DET = 1'b0; pif.TRG_MODE = 1'b0;
      tick();
      chk("trg_no_reset", pif.STORE, 0);
      run_seq();
      chk("evt_store_set", pif.STORE, 1);
      pif.EVT_NUM_END = 1'b1;
      tick();
      chk("evt_abort", pif.STORE, 0);
      pif.EVT_NUM_END = 1'b0;
      pif.PIX_STORE = 1'b0;

      // Memory stepping, READ_MEM=4
      pif.READ_MEM = 4'd4;
      dones = 0;
      for (int k = 0; k < 6; k++) begin
         pif.MEM_SET_EN = 1'b1;
         tick();
         chk($sformatf("step%0d_col", k), pif.COLOUT_SEL, (k < 4) ? k : 3);
         chk($sformatf("step%0d_rp", k), pif.READ_PIX, 1);
         chk($sformatf("step%0d_last", k), pif.LAST_MEM, (k >= 3) ? 1 : 0);
         for (int j = 0; j < 14; j++) begin
            if (pif.MEM_SET_DONE) dones++;
            if (j == 3) pif.MEM_SET_EN = 1'b0;
            tick();
         end
      end
      chk("step_done_count", dones, 6);
      pif.MEM_SET_CLR = 1'b1;
      tick();
      pif.MEM_SET_CLR = 1'b0;
      chk("clr_rp", pif.READ_PIX, 0);
      chk("clr_col", pif.COLOUT_SEL, 0);
      chk("clr_last", pif.LAST_MEM, 0);
      pif.MEM_SET_EN = 1'b1;
      tick();
      pif.MEM_SET_EN = 1'b0;
      chk("restep_rp", pif.READ_PIX, 1);
      chk("restep_col", pif.COLOUT_SEL, 0);
      chk("restep_done", pif.MEM_SET_DONE, 1);
      tick();
      pif.MEM_SET_CLR = 1'b1; pif.MEM_SET_EN = 1'b1;
      tick();
      chk("clr_prio_rp", pif.READ_PIX, 0);
      chk("clr_prio_done", pif.MEM_SET_DONE, 0);
      pif.MEM_SET_CLR = 1'b0; pif.MEM_SET_EN = 1'b0;
      tick();

      // Clamp table
      for (int t = 0; t < 8; t++) begin
         pif.MEM_SET_CLR = 1'b1;
         tick();
         pif.MEM_SET_CLR = 1'b0;
         pif.READ_MEM = tbl[t].read_mem;
         dones = 0;
         for (int s = 0; s < tbl[t].steps; s++) begin
            pif.MEM_SET_EN = 1'b1;
            tick();
            if (pif.MEM_SET_DONE) dones++;
            pif.MEM_SET_EN = 1'b0;
            tick();
         end
         chk($sformatf("tbl%0d_col", t), pif.COLOUT_SEL, tbl[t].col);
         chk($sformatf("tbl%0d_last", t), pif.LAST_MEM, tbl[t].last);
         chk($sformatf("tbl%0d_rp", t), pif.READ_PIX, 1);
         chk($sformatf("tbl%0d_done", t), dones, tbl[t].steps);
      end

      // Reset mid-sequence with PIX_RESET held through reset
      pulse_reset();
      repeat (20) tick();
      chk("midseq_c20", seq_out, exp_seq(20, 1'b0));
      rst = 1'b1; pif.PIX_RESET = 1'b1;
      tick();
      chk("midseq_reset_outs", all_out, 0);
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         if (pif.PIX_END || pif.PIX_RESET_BUSY) seen++;
         tick();
      end
      chk("held_edge_no_start", seen, 0);
      pif.PIX_RESET = 1'b0;
      tick();
      pif.PIX_RESET = 1'b1;
      tick();
      pif.PIX_RESET = 1'b0;
      chk("rearm_start", seq_out, exp_seq(0, 1'b0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // REGOUT delay
      chk("regout_idle", pif.REGOUT_SEL, 0);
      pif.REGOUT_EN = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("regout_hi%0d", i), pif.REGOUT_SEL, 1);
      end
      pif.REGOUT_EN = 1'b0;
      tick();
      chk("regout_lo", pif.REGOUT_SEL, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
